etc_fb_writer: RTL and testbench

ETC_FB_WRITER -- requirements
Module: etc_fb_writer

---
 rtl/etc_fb_pkg.sv | 20 ++
 rtl/etc_fb_writer_if.sv | 23 ++
 rtl/etc_fb_addr_gen.sv | 41 ++++
 rtl/etc_fb_writer.sv | 118 +++++++++++
 tb/tb_etc_fb_writer.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/etc_fb_pkg.sv
// Shared constants, types and helpers for the ETC block frame-buffer writer.
package etc_fb_pkg;

  localparam int BLK_DIM        = 4;
  localparam int TEXELS_PER_BLK = 16;
  localparam int BLK_BITS       = TEXELS_PER_BLK * 16;

  typedef logic [15:0] rgb565_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } fb_state_e;

  function automatic rgb565_t texel_at(input logic [BLK_BITS-1:0] blk, input logic [3:0] idx);
    return blk[{idx, 4'b0000} +: 16];
  endfunction

endpackage

// File: rtl/etc_fb_writer_if.sv
// Block-in / frame-buffer-out signal bundle. slv is the writer side, mst the block source and FB sink.
interface etc_fb_writer_if;
  import etc_fb_pkg::*;

  logic                blk_valid;
  logic [BLK_BITS-1:0] blk_texel;
  logic                blk_ready;
  logic                wr_en;
  logic [31:0]         wr_addr;
  rgb565_t             wr_data;
  logic                decode_finished;

  modport slv (
    input  blk_valid, blk_texel,
    output blk_ready, wr_en, wr_addr, wr_data, decode_finished
  );

  modport mst (
    output blk_valid, blk_texel,
    input  blk_ready, wr_en, wr_addr, wr_data, decode_finished
  );

endinterface

// File: rtl/etc_fb_addr_gen.sv
// Raster address for texel i of block (bx, by), registered; holds while en_i=0.
// Optional ETC_FB_FLIP_Y_EN writes rows bottom-up (HEIGHT-1-y).
module etc_fb_addr_gen
  import etc_fb_pkg::*;
#(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 128,
  parameter int BXW    = 5,
  parameter int BYW    = 5
) (
  input  logic           clk_i,
  input  logic           srst_i,
  input  logic           en_i,
  input  logic [BXW-1:0] bx_i,
  input  logic [BYW-1:0] by_i,
  input  logic [3:0]     idx_i,
  output logic [31:0]    wr_addr_o
);

  logic [31:0] x, y, row, addr_d, addr_q;

  // ETC2 texel order is column-major: idx[3:2] is the column, idx[1:0] the row.
  always_comb begin
    x = 32'(bx_i) * 32'(BLK_DIM) + 32'(idx_i[3:2]);
    y = 32'(by_i) * 32'(BLK_DIM) + 32'(idx_i[1:0]);
`ifdef ETC_FB_FLIP_Y_EN
    row = 32'(HEIGHT - 1) - y;
`else
    row = y;
`endif
    addr_d = row * 32'(WIDTH) + x;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i)    addr_q <= '0;
    else if (en_i) addr_q <= addr_d;
  end

  assign wr_addr_o = addr_q;

endmodule

// File: rtl/etc_fb_writer.sv
// Accepts decoded 4x4 ETC blocks and streams their texels into a raster frame buffer.
// Optional macro ETC_FB_FLIP_Y_EN (handled in etc_fb_addr_gen) flips rows vertically.
module etc_fb_writer
  import etc_fb_pkg::*;
#(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 128
) (
  input  logic          tft_sclk_33m,
  input  logic          srst,
  input  logic          restart,
  etc_fb_writer_if.slv  bus
);

  localparam int BW  = WIDTH / BLK_DIM;
  localparam int BH  = HEIGHT / BLK_DIM;
  localparam int BXW = (BW > 1) ? $clog2(BW) : 1;
  localparam int BYW = (BH > 1) ? $clog2(BH) : 1;

  fb_state_e           state_q, state_d;
  logic [BXW-1:0]      bx_q, bx_d;
  logic [BYW-1:0]      by_q, by_d;
  logic [3:0]          idx_q, idx_d;
  logic [BLK_BITS-1:0] buf_q, buf_d;
  logic                rdy_q, done_q, wr_en_q, wr_en_d;
  rgb565_t             data_q, data_d;
  logic [31:0]         wr_addr;
  logic                hs, last_bx, last_by;

  assign hs      = (state_q == ST_IDLE) && rdy_q && bus.blk_valid && !restart;
  assign last_bx = (bx_q == BXW'(BW - 1));
  assign last_by = (by_q == BYW'(BH - 1));

  // Outputs are registered from next-state values so texel 0 appears the cycle after the handshake.
  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    by_d    = by_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    if (restart) begin
      state_d = ST_IDLE;
      bx_d    = '0;
      by_d    = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (hs) begin
          buf_d   = bus.blk_texel;
          idx_d   = '0;
          state_d = ST_WRITE;
        end
        ST_WRITE: if (idx_q == 4'(TEXELS_PER_BLK - 1)) begin
          idx_d   = '0;
          state_d = (last_bx && last_by) ? ST_DONE : ST_IDLE;
          if (last_bx) begin
            bx_d = '0;
            by_d = last_by ? '0 : by_q + 1'b1;
          end else begin
            bx_d = bx_q + 1'b1;
          end
        end else begin
          idx_d = idx_q + 4'd1;
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
    wr_en_d = (state_d == ST_WRITE);
    data_d  = texel_at(buf_d, idx_d);
  end

  always_ff @(posedge tft_sclk_33m) begin
    if (srst) begin
      state_q <= ST_IDLE;
      bx_q    <= '0;
      by_q    <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      rdy_q   <= (state_d == ST_IDLE);
      done_q  <= (state_d == ST_DONE);
      wr_en_q <= wr_en_d;
      if (wr_en_d) data_q <= data_d;
    end
  end

  etc_fb_addr_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .BXW    (BXW),
    .BYW    (BYW)
  ) u_addr (
    .clk_i     (tft_sclk_33m),
    .srst_i    (srst),
    .en_i      (wr_en_d),
    .bx_i      (bx_q),
    .by_i      (by_q),
    .idx_i     (idx_d),
    .wr_addr_o (wr_addr)
  );

  assign bus.blk_ready       = rdy_q;
  assign bus.wr_en           = wr_en_q;
  assign bus.wr_addr         = wr_addr;
  assign bus.wr_data         = data_q;
  assign bus.decode_finished = done_q;

endmodule

// File: tb/tb_etc_fb_writer.sv
// Directed bench for etc_fb_writer at default 128x128 size (no vertical flip).
module tb_etc_fb_writer;

  logic clk = 1'b0;
  logic srst, restart;
  int   n_chk = 0, n_pass = 0, wr_cnt = 0;
  int   a0tab [16] = '{0, 128, 256, 384, 1, 129, 257, 385,
                       2, 130, 258, 386, 3, 131, 259, 387};

  always #5 clk = ~clk;

  etc_fb_writer_if bus ();

  etc_fb_writer #(.WIDTH(128), .HEIGHT(128)) dut (
    .tft_sclk_33m (clk),
    .srst         (srst),
    .restart      (restart),
    .bus          (bus)
  );

  always @(negedge clk) if (bus.wr_en === 1'b1) wr_cnt = wr_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [255:0] mk_blk(input int blk);
    logic [255:0] t;
    for (int i = 0; i < 16; i++) t[16*i +: 16] = 16'h0100 + 16'(blk * 16 + i);
    return t;
  endfunction

  function automatic int exp_addr(input int blk, input int i);
    int bx, by;
    bx = blk % 32;
    by = blk / 32;
    return (by * 4 + i % 4) * 128 + bx * 4 + i / 4;
  endfunction

  function automatic logic [15:0] exp_data(input int blk, input int i);
    return 16'h0100 + 16'(blk * 16 + i);
  endfunction

  task automatic wait_ready();
    int w = 0;
    while (bus.blk_ready !== 1'b1 && w < 40) begin step(); w++; end
    if (bus.blk_ready !== 1'b1) chk("ready_timeout", {31'b0, bus.blk_ready}, 1);
  endtask

  // Hand a block over, then walk its 16 write cycles.
  task automatic send_block(input int blk, input bit full);
    wait_ready();
    bus.blk_valid = 1'b1;
    bus.blk_texel = mk_blk(blk);
    step();
    bus.blk_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (full) begin
        chk("b0_wr_en", {31'b0, bus.wr_en}, 1);
        chk("b0_addr", bus.wr_addr, a0tab[i]);
        chk("b0_data", {16'b0, bus.wr_data}, 32'h0100 + i);
      end else if (i == 0) begin
        chk("first_wr_en", {31'b0, bus.wr_en}, 1);
        chk("first_addr", bus.wr_addr, exp_addr(blk, 0));
        if (blk == 1)  chk("blk1_first", bus.wr_addr, 4);
        if (blk == 32) chk("blk32_first", bus.wr_addr, 512);
        if (blk == 33) chk("blk33_first", bus.wr_addr, 516);
      end else if (i == 15) begin
        chk("last_addr", bus.wr_addr, exp_addr(blk, 15));
        chk("last_data", {16'b0, bus.wr_data}, {16'b0, exp_data(blk, 15)});
      end
      step();
    end
  endtask

  initial begin
    int c0;
    srst          = 1'b1;
    restart       = 1'b0;
    bus.blk_valid = 1'b0;
    bus.blk_texel = '0;

    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_wr_en", {31'b0, bus.wr_en}, 0);
      chk("rst_addr", bus.wr_addr, 0);
      chk("rst_data", {16'b0, bus.wr_data}, 0);
      chk("rst_done", {31'b0, bus.decode_finished}, 0);
      chk("rst_ready", {31'b0, bus.blk_ready}, 0);
    end
    srst = 1'b0;
    step();
    chk("ready_after_rst", {31'b0, bus.blk_ready}, 1);

    // Whole frame, blocks back-to-back.
    for (int b = 0; b < 1024; b++) begin
      send_block(b, b == 0);
      if (b < 1023) begin
        chk("blk_gap_wr_en", {31'b0, bus.wr_en}, 0);
        chk("blk_gap_ready", {31'b0, bus.blk_ready}, 1);
        chk("blk_gap_done", {31'b0, bus.decode_finished}, 0);
      end
    end
    chk("frame_done", {31'b0, bus.decode_finished}, 1);
    chk("frame_ready", {31'b0, bus.blk_ready}, 0);
    chk("frame_wr_en", {31'b0, bus.wr_en}, 0);
    chk("frame_last_addr", bus.wr_addr, 16383);
    chk("frame_writes", wr_cnt, 16384);

    // DONE ignores blocks.
    bus.blk_valid = 1'b1;
    bus.blk_texel = mk_blk(5);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("done_wr_en", {31'b0, bus.wr_en}, 0);
      chk("done_hold", {31'b0, bus.decode_finished}, 1);
    end
    chk("done_writes", wr_cnt, 16384);
    bus.blk_valid = 1'b0;

    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("rs_done_clr", {31'b0, bus.decode_finished}, 0);
    chk("rs_ready", {31'b0, bus.blk_ready}, 1);
    chk("rs_wr_en", {31'b0, bus.wr_en}, 0);

    // restart beats a simultaneous blk_valid.
    restart       = 1'b1;
    bus.blk_valid = 1'b1;
    bus.blk_texel = mk_blk(9);
    step();
    restart       = 1'b0;
    bus.blk_valid = 1'b0;
    chk("rs_vld_no_wr", {31'b0, bus.wr_en}, 0);
    chk("rs_vld_ready", {31'b0, bus.blk_ready}, 1);
    step();
    chk("rs_vld_no_wr2", {31'b0, bus.wr_en}, 0);

    for (int b = 0; b < 7; b++) send_block(b, 1'b0);

    // Block 7 aborted after its fifth write.
    wait_ready();
    c0            = wr_cnt;
    bus.blk_valid = 1'b1;
    bus.blk_texel = mk_blk(7);
    step();
    bus.blk_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("b7_fifth_addr", bus.wr_addr, exp_addr(7, 4));
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("abort_wr_en", {31'b0, bus.wr_en}, 0);
    chk("abort_count", wr_cnt - c0, 5);
    chk("abort_hold_addr", bus.wr_addr, exp_addr(7, 4));
    for (int k = 0; k < 3; k++) step();
    chk("abort_count2", wr_cnt - c0, 5);
    send_block(0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
